// File: rtl/assoc_cache_pkg.sv
// Shared types and default geometry for the two-way set-associative cache.
`ifndef ALEN
`define ALEN 32
`endif

package assoc_cache_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_SET_BITS = 8;
  localparam int DEF_ADDR_W   = `ALEN - $clog2(DEF_DATA_W / 8);
  localparam int DEF_TAG_W    = DEF_ADDR_W - DEF_SET_BITS;
  localparam int DEF_NUM_SETS = 1 << DEF_SET_BITS;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } cache_state_e;

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_DATA_W-1:0] data;
  } way_entry_t;

endpackage

// File: rtl/assoc_cache_way.sv
// One cache way: per-set valid/tag/data, registered data read, write port and
// a single-set clear port used by the flush sweep.
module assoc_cache_way #(
  parameter int DATA_W   = 64,
  parameter int TAG_W    = 21,
  parameter int SET_BITS = 8
) (
  input  logic                clk,
  input  logic [SET_BITS-1:0] rd_set,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [DATA_W-1:0]   rd_data,
  input  logic [SET_BITS-1:0] wr_set,
  output logic                wr_probe_valid,
  output logic [TAG_W-1:0]    wr_probe_tag,
  input  logic                wr_en,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                clr_en,
  input  logic [SET_BITS-1:0] clr_set
);

  localparam int NUM_SETS = 1 << SET_BITS;

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [DATA_W-1:0]   data_mem [NUM_SETS];
  logic [DATA_W-1:0]   data_p1;

  // Tags are probed in the request cycle so hit and victim decisions settle
  // before the edge; only the wide data array sits behind a read register.
  assign rd_valid       = valid_q[rd_set];
  assign rd_tag         = tag_mem[rd_set];
  assign wr_probe_valid = valid_q[wr_set];
  assign wr_probe_tag   = tag_mem[wr_set];
  assign rd_data        = data_p1;

  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid_q[clr_set] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_set] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_set]  <= wr_tag;
      data_mem[wr_set] <= wr_data;
    end
  end

  // Read-first: a same-edge write to this set is not visible until next read.
  always_ff @(posedge clk) begin
    data_p1 <= data_mem[rd_set];
  end

endmodule

// File: rtl/assoc_cache.sv
// Two-way set-associative single-word cache with true-LRU replacement and a
// set-by-set flush sweep that also runs after reset.
module assoc_cache
  import assoc_cache_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SET_BITS = DEF_SET_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              lookup_valid,
  input  logic              flush_req,
  output logic              flush_busy
);

  localparam int TAG_W    = ADDR_W - SET_BITS;
  localparam int NUM_SETS = 1 << SET_BITS;
  localparam logic [SET_BITS-1:0] SET_LAST = '1;

  if (TAG_W < 1 || DATA_W < 8 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_params
    $error("assoc_cache: TAG_W must be >= 1 and DATA_W a power of two >= 8");
  end

  cache_state_e        state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic                ready;
  logic [NUM_SETS-1:0] lru_q;

  logic [SET_BITS-1:0] rset, wset;
  logic [TAG_W-1:0]    rtag, wtag;
  logic                r_v0, r_v1, w_v0, w_v1;
  logic [TAG_W-1:0]    r_t0, r_t1, w_t0, w_t1;
  logic [DATA_W-1:0]   d0_p1, d1_p1;
  logic                r_hit0, r_hit1, w_hit0, w_hit1;
  logic                wr_acc, wr_way, bypass, look_hit, r_lru_upd;

  logic                vld_p1, byp_p1, way_p1;
  logic [DATA_W-1:0]   wdata_p1;

  assign rset = raddr[SET_BITS-1:0];
  assign rtag = raddr[ADDR_W-1 -: TAG_W];
  assign wset = waddr[SET_BITS-1:0];
  assign wtag = waddr[ADDR_W-1 -: TAG_W];

  assign ready      = (state_q == READY);
  assign flush_busy = ~ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter rolls over to 0 as the sweep finishes, so READY always sees 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SWEEP: begin
        cnt_d = cnt_q + SET_BITS'(1);
        if (cnt_q == SET_LAST) state_d = READY;
      end
      READY: begin
        if (flush_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // ---- stage p0: tag compare, victim choice, LRU update ----
  assign r_hit0 = r_v0 && (r_t0 == rtag);
  assign r_hit1 = r_v1 && (r_t1 == rtag);
  assign w_hit0 = w_v0 && (w_t0 == wtag);
  assign w_hit1 = w_v1 && (w_t1 == wtag);

  assign wr_acc    = write_enable && ready && !flush_req && !rst;
  assign bypass    = wr_acc && (waddr == raddr);
  assign look_hit  = ready && (bypass || r_hit0 || r_hit1);
  assign r_lru_upd = ready && (r_hit0 || r_hit1);

  always_comb begin
    wr_way = lru_q[wset];
    if (w_hit0)     wr_way = 1'b0;
    else if (w_hit1) wr_way = 1'b1;
    else if (!w_v0)  wr_way = 1'b0;
    else if (!w_v1)  wr_way = 1'b1;
  end

  // lru_q names the victim way; the write update is last so it wins a same-set tie.
  always_ff @(posedge clk) begin
    if (!ready) begin
      lru_q[cnt_q] <= 1'b0;
    end else begin
      if (r_lru_upd) lru_q[rset] <= r_hit0;
      if (wr_acc)    lru_q[wset] <= ~wr_way;
    end
  end

  assoc_cache_way #(.DATA_W(DATA_W), .TAG_W(TAG_W), .SET_BITS(SET_BITS)) u_way0 (
    .clk            (clk),
    .rd_set         (rset),
    .rd_valid       (r_v0),
    .rd_tag         (r_t0),
    .rd_data        (d0_p1),
    .wr_set         (wset),
    .wr_probe_valid (w_v0),
    .wr_probe_tag   (w_t0),
    .wr_en          (wr_acc && !wr_way),
    .wr_tag         (wtag),
    .wr_data        (wdata),
    .clr_en         (!ready),
    .clr_set        (cnt_q)
  );

  assoc_cache_way #(.DATA_W(DATA_W), .TAG_W(TAG_W), .SET_BITS(SET_BITS)) u_way1 (
    .clk            (clk),
    .rd_set         (rset),
    .rd_valid       (r_v1),
    .rd_tag         (r_t1),
    .rd_data        (d1_p1),
    .wr_set         (wset),
    .wr_probe_valid (w_v1),
    .wr_probe_tag   (w_t1),
    .wr_en          (wr_acc && wr_way),
    .wr_tag         (wtag),
    .wr_data        (wdata),
    .clr_en         (!ready),
    .clr_set        (cnt_q)
  );

  // ---- stage p1: registered hit flag and output select ----
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= look_hit;
  end

  always_ff @(posedge clk) begin
    byp_p1   <= bypass;
    way_p1   <= r_hit1;
    wdata_p1 <= wdata;
  end

  assign lookup_valid = vld_p1;
  assign rdata = !vld_p1 ? '0 : (byp_p1 ? wdata_p1 : (way_p1 ? d1_p1 : d0_p1));

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed test-plan scenarios plus random traffic, all
// checked every cycle against an MRU-list model of the cache.
module tb_assoc_cache;
  import assoc_cache_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int AW = DEF_ADDR_W;
  localparam int SB = DEF_SET_BITS;
  localparam int NSETS = 1 << SB;
  localparam logic [AW-1:0] IDLE = {{(AW-SB){1'b1}}, 8'h77};

  logic          clk, rst, write_enable, flush_req;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, rdata;
  logic          lookup_valid, flush_busy;

  int n_vec = 0;
  int n_bad = 0;

  assoc_cache dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata), .lookup_valid(lookup_valid),
    .flush_req(flush_req), .flush_busy(flush_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: per set an ordered list (LRU first, MRU last) of up to two addresses.
  int            m_cnt [NSETS];
  logic [AW-1:0] m_lru [NSETS];
  logic [AW-1:0] m_mru [NSETS];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            busy_m = 0;
  bit            armed = 0;
  bit            wacc;
  logic          ev, eb;
  logic [DW-1:0] ed;

  function automatic void m_clear();
    for (int s = 0; s < NSETS; s++) m_cnt[s] = 0;
    mem.delete();
  endfunction

  function automatic bit m_hit(logic [AW-1:0] a);
    int s = int'(a[SB-1:0]);
    return (m_cnt[s] >= 1 && m_mru[s] == a) || (m_cnt[s] == 2 && m_lru[s] == a);
  endfunction

  function automatic void m_touch(logic [AW-1:0] a);
    int s = int'(a[SB-1:0]);
    if (m_cnt[s] == 2 && m_lru[s] == a) begin
      m_lru[s] = m_mru[s];
      m_mru[s] = a;
    end
  endfunction

  function automatic void m_write(logic [AW-1:0] a, logic [DW-1:0] d);
    int s = int'(a[SB-1:0]);
    if (m_hit(a)) m_touch(a);
    else if (m_cnt[s] == 0) begin
      m_mru[s] = a;
      m_cnt[s] = 1;
    end else begin
      if (m_cnt[s] == 2) mem.delete(m_lru[s]);
      m_lru[s] = m_mru[s];
      m_mru[s] = a;
      m_cnt[s] = 2;
    end
    mem[a] = d;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_clear();
      busy_m = NSETS;
      ev = 1'b0; ed = '0; armed = 1;
    end else if (busy_m > 0) begin
      busy_m = busy_m - 1;
      ev = 1'b0; ed = '0;
    end else begin
      wacc = write_enable && !flush_req;
      if (wacc && waddr == raddr) begin
        ev = 1'b1; ed = wdata;
      end else if (m_hit(raddr)) begin
        ev = 1'b1; ed = mem[raddr];
        // A write into the same set this cycle decides recency on its own.
        if (!(wacc && waddr[SB-1:0] == raddr[SB-1:0])) m_touch(raddr);
      end else begin
        ev = 1'b0; ed = '0;
      end
      if (flush_req) begin
        m_clear();
        busy_m = NSETS;
      end else if (write_enable) m_write(waddr, wdata);
    end
    eb = (busy_m > 0);
  end

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("lookup_valid", DW'(lookup_valid), DW'(ev));
      chk("rdata", rdata, ed);
      chk("flush_busy", DW'(flush_busy), DW'(eb));
    end
  end

  logic [7:0] pool_sets [4] = '{8'h12, 8'h00, 8'hFF, 8'h01};

  function automatic logic [AW-1:0] mk(int tag, logic [7:0] set);
    return (AW'(tag) << SB) | AW'(set);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return mk(int'($urandom_range(0, 3)), pool_sets[$urandom_range(0, 3)]);
  endfunction

  task automatic idle();
    write_enable = 1'b0; flush_req = 1'b0;
    waddr = IDLE; raddr = IDLE; wdata = '0;
  endtask

  task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [AW-1:0] ra, input logic fr);
    @(negedge clk);
    write_enable = we; waddr = wa; wdata = wd; raddr = ra; flush_req = fr;
  endtask

  task automatic peek(input string nm, input logic wv, input logic [DW-1:0] wd);
    @(negedge clk);
    chk({nm, "_valid"}, DW'(lookup_valid), DW'(wv));
    chk({nm, "_data"}, rdata, wd);
    idle();
  endtask

  task automatic reset_sweep(input string nm);
    int bc;
    @(negedge clk);
    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    bc = flush_busy ? 1 : 0;
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!flush_busy) break;
      bc++;
      raddr = rand_addr();
    end
    raddr = IDLE;
    chk(nm, DW'(bc), DW'(NSETS));
  endtask

  localparam logic [AW-1:0] A = AW'(32'h000_0012);
  localparam logic [AW-1:0] B = AW'(32'h100_0012);
  localparam logic [AW-1:0] C = AW'(32'h200_0012);
  localparam logic [AW-1:0] X = AW'(32'h0AB_00FF);

  initial begin
    logic [AW-1:0] gone [7];
    int bc;
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);

    // Reset sweep, random lookups must all miss.
    reset_sweep("reset_busy_len");

    // Two conflicting lines in set 0x12.
    cyc(1'b1, A, 64'h1111, IDLE, 1'b0);
    cyc(1'b1, B, 64'h2222, IDLE, 1'b0);
    cyc(1'b0, IDLE, '0, A, 1'b0); peek("read_A", 1'b1, 64'h1111);
    cyc(1'b0, IDLE, '0, B, 1'b0); peek("read_B", 1'b1, 64'h2222);

    // LRU: touching A makes B the victim for C.
    cyc(1'b0, IDLE, '0, A, 1'b0); peek("touch_A", 1'b1, 64'h1111);
    cyc(1'b1, C, 64'h3333, IDLE, 1'b0);
    cyc(1'b0, IDLE, '0, B, 1'b0); peek("evicted_B", 1'b0, '0);
    cyc(1'b0, IDLE, '0, A, 1'b0); peek("kept_A", 1'b1, 64'h1111);
    cyc(1'b0, IDLE, '0, C, 1'b0); peek("filled_C", 1'b1, 64'h3333);

    // Same-cycle bypass, then overwrite hit.
    cyc(1'b1, X, 64'hDEAD, X, 1'b0); peek("bypass", 1'b1, 64'hDEAD);
    cyc(1'b1, X, 64'hBEEF, IDLE, 1'b0);
    cyc(1'b0, IDLE, '0, X, 1'b0); peek("overwrite", 1'b1, 64'hBEEF);

    // Flush with a write in the request cycle, a mid-sweep write and a repeat request.
    cyc(1'b1, AW'(32'h0), 64'hA0, IDLE, 1'b0);
    cyc(1'b1, AW'(32'hFF), 64'hA1, IDLE, 1'b0);
    cyc(1'b0, IDLE, '0, AW'(32'h0), 1'b0); peek("set00", 1'b1, 64'hA0);
    cyc(1'b1, AW'(32'h55), 64'h55, IDLE, 1'b1);
    bc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!flush_busy) break;
      bc++;
      write_enable = (i == 100); waddr = AW'(32'h56); wdata = 64'h56;
      raddr = IDLE; flush_req = (i == 50);
    end
    idle();
    chk("flush_busy_len", DW'(bc), DW'(NSETS));
    gone = '{AW'(32'h0), AW'(32'hFF), AW'(32'h55), AW'(32'h56), A, C, X};
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, IDLE, '0, gone[i], 1'b0);
      peek("after_flush", 1'b0, '0);
    end

    // Reset in the middle of a sweep restarts it from set 0.
    cyc(1'b1, AW'(32'h33), 64'h33, IDLE, 1'b0);
    cyc(1'b0, IDLE, '0, AW'(32'h33), 1'b0); peek("set33", 1'b1, 64'h33);
    cyc(1'b0, IDLE, '0, IDLE, 1'b1);
    @(negedge clk);
    idle();
    repeat (98) @(negedge clk);
    reset_sweep("rst_mid_sweep_len");
    cyc(1'b0, IDLE, '0, AW'(32'h33), 1'b0); peek("after_rst", 1'b0, '0);

    // Random traffic on a small address pool to force conflicts and evictions.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 999) == 0);
      write_enable = 1'($urandom_range(0, 1));
      waddr = rand_addr();
      wdata = {$urandom, $urandom};
      raddr = ($urandom_range(0, 3) == 0) ? waddr : rand_addr();
      flush_req = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
